// File: rtl/shifter_pkg.sv
// shifter_pkg: shared constants for the pipelined shifter.
//   F_*        : fcode operation selects
//   *_BIT      : bit positions of the {s,z,c,v} flags inside code
//   STAGES     : number of register stages in pipe_shifter
package shifter_pkg;

  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_ROL = 4'b1001;
  localparam logic [3:0] F_SRL = 4'b1010;
  localparam logic [3:0] F_SRA = 4'b1011;
  localparam logic [3:0] F_ROR = 4'b1100;

  localparam int S_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam int STAGES = 2;

  function automatic logic is_rot(input logic [3:0] f);
    return (f == F_ROL) || (f == F_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one stage of the log2 shift network, shifting by the fixed
// amount AMT when en is set.
//   fcode      : operation select (unknown codes pass data through)
//   en         : this stage's bit of the shift amount
//   sign       : MSB of the original operand (signed-overflow reference)
//   din/dout   : data into / out of the stage
//   cin/cout   : last bit shifted out so far
//   vin/vout   : sticky SLL overflow so far
// AMT may equal WIDTH; that instance handles the top bit of the amount.
module shift_stage import shifter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic [3:0]       fcode,
  input  logic             en,
  input  logic             sign,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             vout
);

  // Rotating by WIDTH is the identity, so reduce the amount modulo WIDTH.
  localparam int ROT   = AMT % WIDTH;
  localparam int ROT_C = (WIDTH - ROT) % WIDTH;
  // Top AMT bits set: the positions SRA refills with the sign.
  localparam logic [WIDTH-1:0] SIGN_MASK = ~({WIDTH{1'b1}} >> AMT);

  always_comb begin
    dout = din;
    cout = cin;
    vout = vin;
    if (en) begin
      case (fcode)
        F_SLL: begin
          dout = din << AMT;
          cout = din[WIDTH-AMT];
          // any departing bit that differs from the original sign overflows
          vout = vin | (|(din[WIDTH-1 -: AMT] ^ {AMT{sign}}));
        end
        F_SRL: begin
          dout = din >> AMT;
          cout = din[AMT-1];
        end
        F_SRA: begin
          dout = (din >> AMT) | (SIGN_MASK & {WIDTH{din[WIDTH-1]}});
          cout = din[AMT-1];
        end
        F_ROL:   dout = (din << ROT) | (din >> ROT_C);
        F_ROR:   dout = (din >> ROT) | (din << ROT_C);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage pipelined barrel shifter/rotator with flags.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operation handshake (fcode, shift, in)
//   out_valid/out_ready : result handshake (result, code = {s,z,c,v})
// Stage A registers the operation after the low half of the shift network;
// stage B registers the finished result and flags.
module pipe_shifter import shifter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fcode,
  input  logic [SW-1:0]    shift,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       code
);

  localparam int LOG = $clog2(WIDTH);
  localparam int LO  = LOG / 2;       // stages before the A register
  localparam int NHI = LOG - LO + 1;  // stages after it, incl. the amount MSB

  typedef struct packed {
    logic [3:0]       fcode;
    logic [SW-1:0]    shift;
    logic             sign;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             ovf;
  } op_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;  // [0] = input accept this cycle
  logic            in_fire, a_en, b_en;

  op_t              a_n, a_q;
  logic [WIDTH-1:0] result_q, r;
  logic [3:0]       code_q, code_n;
  logic             c_fin, v_fin;

  // ---------------- low half of the network (before stage A)
  logic [LO:0][WIDTH-1:0] lo_d;
  logic [LO:0]            lo_c, lo_v;

  assign lo_d[0] = in;
  assign lo_c[0] = 1'b0;
  assign lo_v[0] = 1'b0;

  for (genvar k = 0; k < LO; k++) begin : g_lo
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
      .fcode (fcode),
      .en    (shift[k]),
      .sign  (in[WIDTH-1]),
      .din   (lo_d[k]),
      .cin   (lo_c[k]),
      .vin   (lo_v[k]),
      .dout  (lo_d[k+1]),
      .cout  (lo_c[k+1]),
      .vout  (lo_v[k+1])
    );
  end

  always_comb begin
    a_n       = '0;
    a_n.fcode = fcode;
    a_n.shift = shift;
    a_n.sign  = in[WIDTH-1];
    a_n.data  = lo_d[LO];
    a_n.carry = lo_c[LO];
    a_n.ovf   = lo_v[LO];
  end

  // ---------------- high half (before stage B); last instance has AMT=WIDTH
  logic [NHI:0][WIDTH-1:0] hi_d;
  logic [NHI:0]            hi_c, hi_v;

  assign hi_d[0] = a_q.data;
  assign hi_c[0] = a_q.carry;
  assign hi_v[0] = a_q.ovf;

  for (genvar j = 0; j < NHI; j++) begin : g_hi
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << (LO + j))) u_stage (
      .fcode (a_q.fcode),
      .en    (a_q.shift[LO+j]),
      .sign  (a_q.sign),
      .din   (hi_d[j]),
      .cin   (hi_c[j]),
      .vin   (hi_v[j]),
      .dout  (hi_d[j+1]),
      .cout  (hi_c[j+1]),
      .vout  (hi_v[j+1])
    );
  end

  // Rotates take their carry from the finished result; a zero amount never
  // produces a carry. SLL also overflows when the new MSB changes sign.
  always_comb begin
    r     = hi_d[NHI];
    c_fin = hi_c[NHI];
    if (is_rot(a_q.fcode))
      c_fin = (|a_q.shift) & ((a_q.fcode == F_ROL) ? r[0] : r[WIDTH-1]);
    v_fin = hi_v[NHI] | ((a_q.fcode == F_SLL) & (r[WIDTH-1] ^ a_q.sign));
    code_n        = '0;
    code_n[S_BIT] = r[WIDTH-1];
    code_n[Z_BIT] = (r == '0);
    code_n[C_BIT] = c_fin;
    code_n[V_BIT] = v_fin;
  end

  // ---------------- handshake
  assign b_en     = !vld_q[2] || out_ready;
  assign a_en     = !vld_q[1] || b_en;
  assign in_ready = !rst && a_en;
  assign in_fire  = in_valid && in_ready;
  assign vld_pipe = {vld_q, in_fire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      a_q      <= '0;
      result_q <= '0;
      code_q   <= '0;
    end else begin
      if (a_en) begin
        vld_q[1] <= vld_pipe[0];
        if (vld_pipe[0]) a_q <= a_n;
      end
      if (b_en) begin
        vld_q[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          result_q <= r;
          code_q   <= code_n;
        end
      end
    end
  end

  assign out_valid = vld_q[2];
  assign result    = result_q;
  assign code      = code_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: self-checking bench for pipe_shifter (WIDTH=16).
// Expected values come from an arithmetic model of the shifter rules and a
// FIFO scoreboard of accepted operations.
module tb_pipe_shifter;
  import shifter_pkg::*;

  localparam int W  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    fcode = '0;
  logic [SW-1:0] shift = '0;
  logic [W-1:0]  din = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [3:0]    code;

  int total = 0;
  int bad   = 0;
  logic [W+3:0] exp_q[$];

  pipe_shifter #(.WIDTH(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fcode     (fcode),
    .shift     (shift),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .code      (code)
  );

  always #5 clk = ~clk;

  // Reference: {result, s, z, c, v} from the operation definitions.
  function automatic logic [W+3:0] model(input logic [3:0] fc, input int n,
                                         input logic [W-1:0] x);
    logic [W-1:0] r;
    logic c, v;
    int m;
    longint sx, prod, sr;
    r = x; c = 1'b0; v = 1'b0;
    m = n % W;
    case (fc)
      4'b1000: begin
        r = (n >= W) ? '0 : (x << n);
        c = (n == 0 || n > W) ? 1'b0 : x[W-n];
        if (n > 0) begin
          // overflow: the exact signed product does not fit in W bits
          sx   = longint'($signed(x));
          prod = sx * (longint'(1) << n);
          sr   = longint'($signed(r));
          v    = (prod != sr);
        end
      end
      4'b1001: begin
        r = (x << m) | (x >> (W - m));
        c = (n == 0) ? 1'b0 : r[0];
      end
      4'b1010: begin
        r = (n >= W) ? '0 : (x >> n);
        c = (n == 0 || n > W) ? 1'b0 : x[n-1];
      end
      4'b1011: begin
        r = (n >= W) ? {W{x[W-1]}} : W'($signed(x) >>> n);
        c = (n == 0) ? 1'b0 : (n >= W) ? x[W-1] : x[n-1];
      end
      4'b1100: begin
        r = (x >> m) | (x << (W - m));
        c = (n == 0) ? 1'b0 : r[W-1];
      end
      default: ;
    endcase
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  // Scoreboard: every delivered result must match the oldest accepted op.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_extra: got result=%h code=%b with no op pending",
                 result, code);
      end else begin
        logic [W+3:0] e;
        e = exp_q.pop_front();
        if ({result, code} !== e) begin
          bad++;
          $display("FAIL scoreboard: got result=%h code=%b expected result=%h code=%b",
                   result, code, e[W+3:4], e[3:0]);
        end
      end
    end
  end

  task automatic send(input logic [3:0] fc, input int sh, input logic [W-1:0] d,
                      input bit rnd);
    bit done = 0;
    in_valid = 1'b1; fcode = fc; shift = SW'(sh); din = d;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rnd) out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(fc, sh, d));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, result, code} !== '0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b result=%h code=%b required all 0",
               out_valid, in_ready, result, code);
    end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; fcode = F_SLL; shift = SW'(4); din = 16'h0001;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: in_ready=%b required=1", in_ready);
    end
    exp_q.push_back(model(F_SLL, 4, 16'h0001));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_directed();
    logic [3:0]   fcs [7] = '{4'h8, 4'hB, 4'hB, 4'h9, 4'hC, 4'hA, 4'h0};
    int           shs [7] = '{1, 15, 16, 1, 17, 1, 3};
    logic [W-1:0] ins [7] = '{16'h8001, 16'h8000, 16'h8000, 16'h8001,
                              16'h0001, 16'h0001, 16'h1234};
    logic [W-1:0] ers [7] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h0003,
                              16'h8000, 16'h0000, 16'h1234};
    logic [3:0]   ecs [7] = '{4'b0011, 4'b1000, 4'b1010, 4'b0010,
                              4'b1010, 4'b0110, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(fcs[i], shs[i], ins[i], 1'b0);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency_early[%0d]: out_valid=%b required=0", i, out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== ers[i] || code !== ecs[i]) begin
        bad++;
        $display("FAIL directed[%0d]: out_valid=%b result=%h code=%b required 1 %h %b",
                 i, out_valid, result, code, ers[i], ecs[i]);
      end
      wait_drain();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]   fcs [3] = '{4'h8, 4'hA, 4'h9};
    int           shs [3] = '{3, 2, 5};
    logic [W-1:0] ds  [3] = '{16'h1357, 16'hF00F, 16'h8421};
    int acc = 0;
    logic [W+3:0] held;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (acc < 3);
      if (acc < 3) begin
        fcode = fcs[acc]; shift = SW'(shs[acc]); din = ds[acc];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(fcs[acc], shs[acc], ds[acc]));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (acc !== 2) begin
      bad++;
      $display("FAIL bp_accepted: got=%0d required=2", acc);
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    held = {result, code};
    total++;
    if (exp_q.size() == 0 || held !== exp_q[0]) begin
      bad++;
      $display("FAIL bp_head: got=%h required=%h", held, (exp_q.size() != 0) ? exp_q[0] : '0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({result, code} !== held || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got=%h valid=%b required=%h valid=1",
                 i, {result, code}, out_valid, held);
      end
    end
    out_ready = 1'b1;
    send(fcs[2], shs[2], ds[2], 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    logic [W-1:0] specials [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
    logic [3:0] fcs [5] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    for (int i = 0; i < 300; i++) begin
      logic [3:0] fc;
      logic [W-1:0] d;
      fc = ($urandom_range(9) < 8) ? fcs[$urandom_range(4)] : 4'($urandom_range(15));
      d  = ($urandom_range(5) == 0) ? specials[$urandom_range(3)] : W'($urandom);
      send(fc, int'($urandom_range(31)), d, 1'b1);
      if ($urandom_range(4) == 0) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(F_SLL, 2, 16'h00F0, 1'b0);
    send(F_ROR, 9, 16'hABCD, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, result, code} !== '0) begin
      bad++;
      $display("FAIL reset_midstream: out_valid=%b in_ready=%b result=%h code=%b required all 0",
               out_valid, in_ready, result, code);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_after_reset[%0d]: out_valid=%b required=0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    send(F_SRA, 3, 16'h8010, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
